countdown_ctrl: RTL and testbench

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: HH-MM-SS BCD countdown timer with button-driven preset editing.
// Ports: clk, rst (sync, active-high), sec_tick, btn_mode/inc/start/clr (1-clk pulses);
//        edit_val/run_val (32b BCD with 4'hb separators), state (edit digit), go, finish.
// Build option: define COUNTDOWN_DONE_TIMEOUT_EN to auto-exit DONE after DONE_TIMEOUT ticks.
module countdown_ctrl #(
  parameter int DONE_TIMEOUT = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_start,
  input  logic        btn_clr,
  output logic [31:0] edit_val,
  output logic [31:0] run_val,
  output logic [3:0]  state,
  output logic        go,
  output logic        finish
);

  typedef enum logic [1:0] {
    S_EDIT,
    S_RUN,
    S_PAUSE,
    S_DONE
  } fsm_t;

  // Digits are stored packed as six nibbles:
  // [23:20] h10 [19:16] h1 [15:12] m10 [11:8] m1 [7:4] s10 [3:0] s1.
  // The separator nibbles only exist at the output.
  fsm_t        r_fsm;
  logic [23:0] r_edit;
  logic [23:0] r_run;
  logic [3:0]  r_sel;
  logic        r_go;
  logic        r_fin;

  logic [23:0] w_edit_inc;
  logic [23:0] w_run_dec;
  logic        w_edit_zero;
  logic        w_dec_zero;
  logic [3:0]  w_sel_next;

`ifdef COUNTDOWN_DONE_TIMEOUT_EN
  localparam int TW = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DONE_TIMEOUT != 0);
`endif

  function automatic logic [31:0] f_fmt(input logic [23:0] d);
    return {d[23:16], 4'hb, d[15:8], 4'hb, d[7:0]};
  endfunction

  // One-second BCD decrement; callers guarantee a nonzero input.
  function automatic logic [23:0] f_dec(input logic [23:0] d);
    logic [3:0] h10, h1, m10, m1, s10, s1;
    {h10, h1, m10, m1, s10, s1} = d;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1 = 4'd9;
          if (m10 != 4'd0) begin
            m10 = m10 - 4'd1;
          end else begin
            m10 = 4'd5;
            if (h1 != 4'd0) begin
              h1 = h1 - 4'd1;
            end else begin
              h1  = 4'd9;
              h10 = h10 - 4'd1;
            end
          end
        end
      end
    end
    return {h10, h1, m10, m1, s10, s1};
  endfunction

  // Increment only the selected nibble; tens-of-minutes/seconds wrap at 5.
  always_comb begin
    w_edit_inc = r_edit;
    for (int k = 1; k <= 6; k++) begin
      if (r_sel == 4'(k)) begin
        if (((k == 2) || (k == 4)) ? (r_edit[4*(k-1) +: 4] >= 4'd5)
                                   : (r_edit[4*(k-1) +: 4] >= 4'd9))
          w_edit_inc[4*(k-1) +: 4] = 4'd0;
        else
          w_edit_inc[4*(k-1) +: 4] = r_edit[4*(k-1) +: 4] + 4'd1;
      end
    end
  end

  assign w_sel_next  = (r_sel == 4'd0) ? 4'd6 : r_sel - 4'd1;
  assign w_edit_zero = (r_edit == 24'd0);
  assign w_run_dec   = f_dec(r_run);
  assign w_dec_zero  = (w_run_dec == 24'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm  <= S_EDIT;
      r_edit <= '0;
      r_run  <= '0;
      r_sel  <= '0;
      r_go   <= 1'b0;
      r_fin  <= 1'b0;
`ifdef COUNTDOWN_DONE_TIMEOUT_EN
      r_tmo  <= '0;
`endif
    end else if (btn_clr) begin
      r_fsm <= S_EDIT;
      r_run <= '0;
      r_sel <= '0;
      r_go  <= 1'b0;
      r_fin <= 1'b0;
    end else begin
      case (r_fsm)
        S_EDIT: begin
          if (btn_start) begin
            if (!w_edit_zero) begin
              r_run <= r_edit;
              r_sel <= '0;
              r_go  <= 1'b1;
              r_fsm <= S_RUN;
            end
          end else if (btn_mode) begin
            r_sel <= w_sel_next;
          end else if (btn_inc) begin
            r_edit <= w_edit_inc;
          end
        end
        S_RUN: begin
          // A start press wins over a coincident tick: that tick is lost.
          if (btn_start) begin
            r_fsm <= S_PAUSE;
          end else if (sec_tick) begin
            if (w_dec_zero) begin
              r_run <= '0;
              r_go  <= 1'b0;
              r_fin <= 1'b1;
              r_fsm <= S_DONE;
`ifdef COUNTDOWN_DONE_TIMEOUT_EN
              r_tmo <= '0;
`endif
            end else begin
              r_run <= w_run_dec;
            end
          end
        end
        S_PAUSE: begin
          if (btn_start)
            r_fsm <= S_RUN;
        end
        S_DONE: begin
          if (btn_start || btn_mode || btn_inc) begin
            r_fin <= 1'b0;
            r_go  <= 1'b0;
            r_fsm <= S_EDIT;
          end
`ifdef COUNTDOWN_DONE_TIMEOUT_EN
          else if (sec_tick) begin
            if (r_tmo == TW'(DONE_TIMEOUT - 1)) begin
              r_fin <= 1'b0;
              r_fsm <= S_EDIT;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
`endif
        end
        default: begin
          r_fsm <= S_EDIT;
        end
      endcase
    end
  end

  assign edit_val = f_fmt(r_edit);
  assign run_val  = f_fmt(r_run);
  assign state    = r_sel;
  assign go       = r_go;
  assign finish   = r_fin;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: scoreboard bench for countdown_ctrl.
// Integer-seconds reference model predicts every cycle's outputs.
module tb_countdown_ctrl;

  logic        clk = 1'b0;
  logic        rst, sec_tick, btn_mode, btn_inc, btn_start, btn_clr;
  logic [31:0] edit_val, run_val;
  logic [3:0]  state;
  logic        go, finish;

  localparam int TO = 3;

  localparam bit [5:0] R = 6'b100000;
  localparam bit [5:0] T = 6'b010000;
  localparam bit [5:0] M = 6'b001000;
  localparam bit [5:0] I = 6'b000100;
  localparam bit [5:0] S = 6'b000010;
  localparam bit [5:0] C = 6'b000001;

  always #5 clk = ~clk;

  countdown_ctrl #(.DONE_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_start(btn_start),
    .btn_clr  (btn_clr),
    .edit_val (edit_val),
    .run_val  (run_val),
    .state    (state),
    .go       (go),
    .finish   (finish)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model: md[0]=sec ones .. md[5]=hour tens; mf 0 edit 1 run 2 pause 3 done
  int md[6];
  int ms, mr, mf, mt;
  bit mgo, mfin;

  typedef struct {
    string          nm;
    logic [69:0]    v;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] fmt(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'hb, 4'(m / 10), 4'(m % 10), 4'hb,
            4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int secs();
    return (md[5] * 10 + md[4]) * 3600 + (md[3] * 10 + md[2]) * 60 +
           md[1] * 10 + md[0];
  endfunction

  function automatic logic [69:0] expv();
    return {fmt(secs()), fmt(mr), 4'(ms), mgo, mfin};
  endfunction

  function automatic logic [69:0] obs();
    return {edit_val, run_val, state, go, finish};
  endfunction

  task automatic model(input bit [5:0] ev);
    int idx, mx;
    if (ev[5]) begin
      foreach (md[k]) md[k] = 0;
      ms = 0; mr = 0; mf = 0; mt = 0; mgo = 0; mfin = 0;
    end else if (ev[0]) begin
      mf = 0; mgo = 0; mfin = 0; ms = 0; mr = 0;
    end else begin
      case (mf)
        0: begin
          if (ev[1]) begin
            if (secs() != 0) begin
              mr = secs(); ms = 0; mgo = 1; mf = 1;
            end
          end else if (ev[3]) begin
            ms = (ms == 0) ? 6 : ms - 1;
          end else if (ev[2] && ms != 0) begin
            idx = ms - 1;
            mx = (ms == 2 || ms == 4) ? 6 : 10;
            md[idx] = (md[idx] + 1) % mx;
          end
        end
        1: begin
          if (ev[1]) begin
            mf = 2;
          end else if (ev[4]) begin
            mr = mr - 1;
            if (mr == 0) begin
              mf = 3; mgo = 0; mfin = 1; mt = 0;
            end
          end
        end
        2: begin
          if (ev[1]) mf = 1;
        end
        default: begin
          if (ev[1] || ev[2] || ev[3]) begin
            mf = 0; mfin = 0;
          end
`ifdef COUNTDOWN_DONE_TIMEOUT_EN
          else if (ev[4]) begin
            mt = mt + 1;
            if (mt == TO) begin
              mf = 0; mfin = 0;
            end
          end
`endif
        end
      endcase
    end
  endtask

  task automatic step(input bit [5:0] ev);
    {rst, sec_tick, btn_mode, btn_inc, btn_start, btn_clr} = ev;
    @(posedge clk);
    #1;
    {rst, sec_tick, btn_mode, btn_inc, btn_start, btn_clr} = '0;
  endtask

  task automatic do_op(input bit [5:0] ev);
    model(ev);
    step(ev);
  endtask

  // Drive the edit digits to h:m:s with mode/inc presses.
  task automatic preset(input int h, input int m, input int s);
    int tgt[6];
    tgt = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    for (int i = 5; i >= 0; i--) begin
      while (ms != i + 1) do_op(M);
      while (md[i] != tgt[i]) do_op(I);
    end
    while (ms != 0) do_op(M);
  endtask

  task automatic test_reset();
    bit [5:0] ops[$];
    exp_t x;
    ops = '{R | T | M | I | S | C, R};
    foreach (ops[k]) begin
      model(ops[k]);
      x.nm = $sformatf("reset[%0d]", k);
      x.v = expv();
      sb.push_back(x);
      step(ops[k]);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", x.nm, obs(), x.v);
      end
    end
  endtask

  task automatic test_edit();
    bit [5:0] ops[$];
    exp_t x;
    ops.push_back(M);
    repeat (10) ops.push_back(I);
    repeat (4) ops.push_back(M);
    repeat (6) ops.push_back(I);
    repeat (2) ops.push_back(M);
    ops.push_back(I);
    foreach (ops[k]) begin
      model(ops[k]);
      x.nm = $sformatf("edit[%0d]", k);
      x.v = expv();
      sb.push_back(x);
      step(ops[k]);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", x.nm, obs(), x.v);
      end
    end
  endtask

  task automatic test_start_zero();
    bit [5:0] ops[$];
    exp_t x;
    ops = '{S, T, S, C};
    foreach (ops[k]) begin
      model(ops[k]);
      x.nm = $sformatf("start_zero[%0d]", k);
      x.v = expv();
      sb.push_back(x);
      step(ops[k]);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", x.nm, obs(), x.v);
      end
    end
  endtask

  task automatic test_minute_borrow();
    bit [5:0] ops[$];
    exp_t x;
    preset(0, 1, 0);
    ops.push_back(S);
    repeat (60) ops.push_back(T);
    foreach (ops[k]) begin
      model(ops[k]);
      x.nm = $sformatf("min_borrow[%0d]", k);
      x.v = expv();
      sb.push_back(x);
      step(ops[k]);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", x.nm, obs(), x.v);
      end
    end
  endtask

  task automatic test_done_hold();
    bit [5:0] ops[$];
    exp_t x;
`ifdef COUNTDOWN_DONE_TIMEOUT_EN
    repeat (TO + 1) ops.push_back(T);
`else
    repeat (100) ops.push_back(T);
`endif
    ops.push_back(I);
    ops.push_back(I);
    foreach (ops[k]) begin
      model(ops[k]);
      x.nm = $sformatf("done_hold[%0d]", k);
      x.v = expv();
      sb.push_back(x);
      step(ops[k]);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", x.nm, obs(), x.v);
      end
    end
  endtask

  task automatic test_hour_borrow();
    bit [5:0] ops[$];
    exp_t x;
    preset(1, 0, 0);
    ops = '{S, T, M, I, C};
    foreach (ops[k]) begin
      model(ops[k]);
      x.nm = $sformatf("hour_borrow[%0d]", k);
      x.v = expv();
      sb.push_back(x);
      step(ops[k]);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", x.nm, obs(), x.v);
      end
    end
  endtask

  task automatic test_pause();
    bit [5:0] ops[$];
    exp_t x;
    preset(0, 0, 5);
    ops = '{S, S | T, T, T, T, I, M, S, T, T, R};
    foreach (ops[k]) begin
      model(ops[k]);
      x.nm = $sformatf("pause[%0d]", k);
      x.v = expv();
      sb.push_back(x);
      step(ops[k]);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", x.nm, obs(), x.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit [5:0] ops[$];
    exp_t x;
    preset(0, 0, 2);
    ops = '{S, T, T, S, S, T, C, M};
    foreach (ops[k]) begin
      model(ops[k]);
      x.nm = $sformatf("b2b[%0d]", k);
      x.v = expv();
      sb.push_back(x);
      step(ops[k]);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", x.nm, obs(), x.v);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    {rst, sec_tick, btn_mode, btn_inc, btn_start, btn_clr} = '0;
    test_reset();
    test_edit();
    test_start_zero();
    test_minute_borrow();
    test_done_hold();
    test_hour_borrow();
    test_pause();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
